param_spec_tlb: RTL and testbench
=================================

// Module: param_spec_tlb
// PURPOSE
//  Parametrised speculative TLB: translates VIRT_ADDR_LOOKUP to PHY_ADDR_TRANS using a fully-associative table holding base and large pages.
//  On miss it issues one request/done page-walk handshake to an external page-table walker (base- or large-page walk).
//  Sits between the requesting core/testbench and the PAGE_TABLE_8B/32B-style walkers.
// PARAMETERS
//  VA_W         8  virtual address width
//  PA_W         8  physical address width
//  BASE_OFF_W   3  base-page offset bits (8B page)
//  LARGE_OFF_W  5  large-page offset bits (32B page), > BASE_OFF_W
//  ENTRIES      8  TLB entries, power of 2, >= 2
// PORTS
//  clk              in   1                 clock, all logic on posedge
//  rst              in   1                 synchronous, active-high reset
//  TRANS_RQST       in   1                 translation request, accepted when RQST_READY=1
//  SPEC_TLB_RQST    in   1                 request may use large-page (speculative) entries/walk
//  VIRT_ADDR_LOOKUP in   VA_W              virtual address, sampled on accept
//  FLUSH            in   1                 invalidate all entries
//  RQST_READY       out  1                 block idle and able to accept
//  DONE_TRANS       out  1                 one-cycle pulse: result valid
//  TLB_HIT          out  1                 result came from TLB (no walk)
//  SPEC_HIT         out  1                 hit was on a large-page entry
//  FAULT            out  1                 walker reported fault
//  PHY_ADDR_TRANS   out  PA_W              translated address
//  WALK_RQST        out  1                 page-walk request, held until WALK_DONE
//  WALK_LARGE       out  1                 1 = large-page walk, 0 = base-page walk
//  WALK_VPN         out  VA_W-BASE_OFF_W   base VPN of missing address
//  WALK_DONE        in   1                 walker completion, sampled only while WALK_RQST=1
//  WALK_FAULT       in   1                 valid with WALK_DONE: no mapping
//  WALK_PPN         in   PA_W-BASE_OFF_W   returned PPN, valid with WALK_DONE
// BEHAVIOUR
//  Reset: all entries invalid, RR pointer 0, state IDLE, every output 0 (PHY_ADDR_TRANS=0); rst wins over all inputs.
//  Entry: valid, large, tag VPN[VA_W-1:BASE_OFF_W], PPN[PA_W-1:BASE_OFF_W]; large entries compare/substitute only bits above LARGE_OFF_W.
//  FSM: IDLE -> LOOKUP (accept) -> RESP (hit) | WALK (miss); WALK -> RESP on WALK_DONE; RESP -> IDLE.
//  RQST_READY = (state==IDLE) && !FLUSH && !flush_pending.
//  LOOKUP: parallel compare; base-entry match always eligible; large-entry match only if SPEC_TLB_RQST. Base match beats large; multiple base hits -> lowest index.
//  Hit latency: accept edge E0, DONE_TRANS high in cycle after E1 (2 cycles). PA = {PPN, VA offset} with offset width per entry size.
//  Miss: WALK_RQST=1 from cycle after E1; WALK_LARGE=SPEC_TLB_RQST captured; WALK_VPN stable while held.
//  WALK_DONE & !WALK_FAULT: fill entry, DONE_TRANS next cycle with TLB_HIT=0, SPEC_HIT=0, PA from WALK_PPN. For a large walk, low (LARGE_OFF_W-BASE_OFF_W) bits of WALK_PPN are ignored (taken from VA).
//  WALK_DONE & WALK_FAULT: no fill; FAULT=1, PHY_ADDR_TRANS=0.
//  Fill slot: lowest-index invalid entry; if none, RR pointer slot, then pointer += 1 mod ENTRIES (wraps ENTRIES-1 -> 0). Pointer advances only on replacing fills.
//  Duplicate fill (same tag+size already valid) overwrites that entry instead.
//  Result outputs (TLB_HIT, SPEC_HIT, FAULT, PHY_ADDR_TRANS) hold until the next DONE_TRANS; DONE_TRANS is exactly one cycle.
//  FLUSH in IDLE: all valid bits cleared at that edge, RR pointer -> 0, request ignored same cycle. FLUSH outside IDLE: latched, applied on return to IDLE, after current result.
//  TRANS_RQST while not ready: ignored, no queueing. WALK_DONE outside WALK: ignored.
//  rst mid-walk: WALK_RQST low the cycle after; no DONE_TRANS for the aborted request.
// CONFIGURATION
//  STLB_PERF_CNT_EN defined: outputs HIT_CNT, SPEC_HIT_CNT, MISS_CNT (16 bits each), incremented on each DONE_TRANS by class, saturating at 16'hFFFF, cleared by rst (not by FLUSH).
//  Not defined: ports present, tied to 0; no counter logic.
// TESTING
//  rst, non-spec VA 8'h2D cold -> WALK_RQST, WALK_LARGE=0, WALK_VPN=5'h05; PPN 5'h11 -> PA 8'h8D, TLB_HIT=0.
//  Repeat VA 8'h2D -> DONE_TRANS 2 cycles after accept, TLB_HIT=1, SPEC_HIT=0, PA 8'h8D, no WALK_RQST.
//  Spec VA 8'h47 miss, WALK_PPN 5'b10111 -> PA 8'hA7; then spec VA 8'h5A -> SPEC_HIT=1, PA 8'hBA; non-spec VA 8'h5A -> miss/walk.
//  Fill 9 distinct base pages -> 9th replaces entry 0; 10th replaces entry 1; VA of first page then misses.
//  WALK_FAULT=1 -> FAULT=1, PA 0, same VA misses again; FLUSH during walk -> result delivered, then all prior VAs miss.
//  rst asserted while WALK_RQST=1 -> WALK_RQST 0 next cycle, no DONE_TRANS, late WALK_DONE ignored, RQST_READY=1.

Source files
------------

// File: rtl/param_spec_tlb.sv
// Speculative TLB: fully-associative base/large-page table with a single walker handshake on miss.
// Optional perf counters are enabled with `define STLB_PERF_CNT_EN; otherwise the counter ports read 0.
module param_spec_tlb #(
    parameter int unsigned VA_W        = 8,
    parameter int unsigned PA_W        = 8,
    parameter int unsigned BASE_OFF_W  = 3,
    parameter int unsigned LARGE_OFF_W = 5,
    parameter int unsigned ENTRIES     = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       TRANS_RQST,
    input  logic                       SPEC_TLB_RQST,
    input  logic [VA_W-1:0]            VIRT_ADDR_LOOKUP,
    input  logic                       FLUSH,
    output logic                       RQST_READY,
    output logic                       DONE_TRANS,
    output logic                       TLB_HIT,
    output logic                       SPEC_HIT,
    output logic                       FAULT,
    output logic [PA_W-1:0]            PHY_ADDR_TRANS,
    output logic                       WALK_RQST,
    output logic                       WALK_LARGE,
    output logic [VA_W-BASE_OFF_W-1:0] WALK_VPN,
    input  logic                       WALK_DONE,
    input  logic                       WALK_FAULT,
    input  logic [PA_W-BASE_OFF_W-1:0] WALK_PPN,
    output logic [15:0]                HIT_CNT,
    output logic [15:0]                SPEC_HIT_CNT,
    output logic [15:0]                MISS_CNT
);
    localparam int unsigned VPN_W = VA_W - BASE_OFF_W;
    localparam int unsigned PPN_W = PA_W - BASE_OFF_W;
    localparam int unsigned LDIFF = LARGE_OFF_W - BASE_OFF_W;
    localparam int unsigned IDX_W = $clog2(ENTRIES);

    typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_WALK, S_RESP} state_t;

    state_t            state_q, state_d;
    logic [VA_W-1:0]   va_q;
    logic              spec_q;
    logic              flush_pend_q;
    logic [ENTRIES-1:0] valid_q, large_q;
    logic [VPN_W-1:0]  tag_q [ENTRIES];
    logic [PPN_W-1:0]  ppn_q [ENTRIES];
    logic [IDX_W-1:0]  rr_q;
    logic              res_hit_q, res_spec_q, res_fault_q;
    logic [PA_W-1:0]   res_pa_q;

    logic [VPN_W-1:0]  vpn;
    logic              base_hit, large_hit, dup_hit, free_hit;
    logic [IDX_W-1:0]  base_idx, large_idx, dup_idx, free_idx, fill_idx;
    logic              fill_adv;
    logic [PA_W-1:0]   hit_pa, walk_pa;
    logic              accept, flush_now;

    assign vpn        = va_q[VA_W-1:BASE_OFF_W];
    assign RQST_READY = !rst && (state_q == S_IDLE) && !FLUSH && !flush_pend_q;
    assign accept     = TRANS_RQST && (state_q == S_IDLE) && !FLUSH && !flush_pend_q;
    assign flush_now  = (state_q == S_IDLE) && (FLUSH || flush_pend_q);

    // Large entries match on the VPN bits above the large-page offset only.
    always_comb begin
        base_hit  = 1'b0;
        base_idx  = '0;
        large_hit = 1'b0;
        large_idx = '0;
        dup_hit   = 1'b0;
        dup_idx   = '0;
        free_hit  = 1'b0;
        free_idx  = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (!base_hit && valid_q[i] && !large_q[i] && tag_q[i] == vpn) begin
                base_hit = 1'b1;
                base_idx = IDX_W'(i);
            end
            if (!large_hit && valid_q[i] && large_q[i] && spec_q &&
                tag_q[i][VPN_W-1:LDIFF] == vpn[VPN_W-1:LDIFF]) begin
                large_hit = 1'b1;
                large_idx = IDX_W'(i);
            end
            if (!dup_hit && valid_q[i] && large_q[i] == spec_q &&
                (spec_q ? (tag_q[i][VPN_W-1:LDIFF] == vpn[VPN_W-1:LDIFF]) : (tag_q[i] == vpn))) begin
                dup_hit = 1'b1;
                dup_idx = IDX_W'(i);
            end
            if (!free_hit && !valid_q[i]) begin
                free_hit = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
        fill_adv = !dup_hit && !free_hit;
        fill_idx = dup_hit ? dup_idx : (free_hit ? free_idx : rr_q);
        if (base_hit)
            hit_pa = {ppn_q[base_idx], va_q[BASE_OFF_W-1:0]};
        else
            hit_pa = {ppn_q[large_idx][PPN_W-1:LDIFF], va_q[LARGE_OFF_W-1:0]};
        if (spec_q)
            walk_pa = {WALK_PPN[PPN_W-1:LDIFF], va_q[LARGE_OFF_W-1:0]};
        else
            walk_pa = {WALK_PPN, va_q[BASE_OFF_W-1:0]};
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (accept) state_d = S_LOOKUP;
            S_LOOKUP: state_d = (base_hit || large_hit) ? S_RESP : S_WALK;
            S_WALK:   if (WALK_DONE) state_d = S_RESP;
            S_RESP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            va_q         <= '0;
            spec_q       <= 1'b0;
            flush_pend_q <= 1'b0;
            valid_q      <= '0;
            large_q      <= '0;
            rr_q         <= '0;
            res_hit_q    <= 1'b0;
            res_spec_q   <= 1'b0;
            res_fault_q  <= 1'b0;
            res_pa_q     <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                tag_q[i] <= '0;
                ppn_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            if (accept) begin
                va_q   <= VIRT_ADDR_LOOKUP;
                spec_q <= SPEC_TLB_RQST;
            end
            if (flush_now) begin
                valid_q      <= '0;
                rr_q         <= '0;
                flush_pend_q <= 1'b0;
            end else if (state_q != S_IDLE && FLUSH) begin
                flush_pend_q <= 1'b1;
            end
            if (state_q == S_LOOKUP && (base_hit || large_hit)) begin
                res_hit_q   <= 1'b1;
                res_spec_q  <= !base_hit;
                res_fault_q <= 1'b0;
                res_pa_q    <= hit_pa;
            end
            if (state_q == S_WALK && WALK_DONE) begin
                res_hit_q   <= 1'b0;
                res_spec_q  <= 1'b0;
                res_fault_q <= WALK_FAULT;
                res_pa_q    <= WALK_FAULT ? '0 : walk_pa;
                if (!WALK_FAULT) begin
                    valid_q[fill_idx] <= 1'b1;
                    large_q[fill_idx] <= spec_q;
                    tag_q[fill_idx]   <= vpn;
                    ppn_q[fill_idx]   <= WALK_PPN;
                    if (fill_adv)
                        rr_q <= rr_q + IDX_W'(1);
                end
            end
        end
    end

    assign DONE_TRANS     = (state_q == S_RESP);
    assign TLB_HIT        = res_hit_q;
    assign SPEC_HIT       = res_spec_q;
    assign FAULT          = res_fault_q;
    assign PHY_ADDR_TRANS = res_pa_q;
    assign WALK_RQST      = (state_q == S_WALK);
    assign WALK_LARGE     = (state_q == S_WALK) && spec_q;
    assign WALK_VPN       = vpn;

`ifdef STLB_PERF_CNT_EN
    logic [15:0] hit_cnt_q, spec_cnt_q, miss_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            spec_cnt_q <= '0;
            miss_cnt_q <= '0;
        end else if (state_q == S_RESP) begin
            if (res_hit_q && !res_spec_q && hit_cnt_q != '1)
                hit_cnt_q <= hit_cnt_q + 16'd1;
            if (res_hit_q && res_spec_q && spec_cnt_q != '1)
                spec_cnt_q <= spec_cnt_q + 16'd1;
            if (!res_hit_q && miss_cnt_q != '1)
                miss_cnt_q <= miss_cnt_q + 16'd1;
        end
    end

    assign HIT_CNT      = hit_cnt_q;
    assign SPEC_HIT_CNT = spec_cnt_q;
    assign MISS_CNT     = miss_cnt_q;
`else
    assign HIT_CNT      = '0;
    assign SPEC_HIT_CNT = '0;
    assign MISS_CNT     = '0;
`endif
endmodule

// File: tb/tb_param_spec_tlb.sv
// Bench for param_spec_tlb: table-driven translations with a scoreboard, plus flush/replacement/reset sequences.
module tb_param_spec_tlb;
    logic       clk = 1'b0;
    logic       rst, TRANS_RQST, SPEC_TLB_RQST, FLUSH;
    logic [7:0] VIRT_ADDR_LOOKUP;
    logic       RQST_READY, DONE_TRANS, TLB_HIT, SPEC_HIT, FAULT;
    logic [7:0] PHY_ADDR_TRANS;
    logic       WALK_RQST, WALK_LARGE, WALK_DONE, WALK_FAULT;
    logic [4:0] WALK_VPN, WALK_PPN;
    logic [15:0] HIT_CNT, SPEC_HIT_CNT, MISS_CNT;

    always #5 clk = ~clk;

    param_spec_tlb #(.VA_W(8), .PA_W(8), .BASE_OFF_W(3), .LARGE_OFF_W(5), .ENTRIES(8)) dut (
        .clk(clk), .rst(rst), .TRANS_RQST(TRANS_RQST), .SPEC_TLB_RQST(SPEC_TLB_RQST),
        .VIRT_ADDR_LOOKUP(VIRT_ADDR_LOOKUP), .FLUSH(FLUSH), .RQST_READY(RQST_READY),
        .DONE_TRANS(DONE_TRANS), .TLB_HIT(TLB_HIT), .SPEC_HIT(SPEC_HIT), .FAULT(FAULT),
        .PHY_ADDR_TRANS(PHY_ADDR_TRANS), .WALK_RQST(WALK_RQST), .WALK_LARGE(WALK_LARGE),
        .WALK_VPN(WALK_VPN), .WALK_DONE(WALK_DONE), .WALK_FAULT(WALK_FAULT), .WALK_PPN(WALK_PPN),
        .HIT_CNT(HIT_CNT), .SPEC_HIT_CNT(SPEC_HIT_CNT), .MISS_CNT(MISS_CNT)
    );

    typedef struct {
        logic [7:0] va;
        logic       spec;
        logic       walk;
        logic       wlarge;
        logic [4:0] wvpn;
        logic [4:0] wppn;
        logic       wfault;
        logic       flush_in_walk;
        logic       hit;
        logic       shit;
        logic       fault;
        logic [7:0] pa;
    } vec_t;

    vec_t sb[$];
    vec_t tbl[10];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] va, input logic spec, input logic walk,
                                input logic wlarge, input logic [4:0] wvpn, input logic [4:0] wppn,
                                input logic wfault, input logic hit, input logic shit,
                                input logic fault, input logic [7:0] pa);
        vec_t v;
        v.va = va; v.spec = spec; v.walk = walk; v.wlarge = wlarge; v.wvpn = wvpn;
        v.wppn = wppn; v.wfault = wfault; v.flush_in_walk = 1'b0;
        v.hit = hit; v.shit = shit; v.fault = fault; v.pa = pa;
        return v;
    endfunction

    task automatic reset_dut();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run(input vec_t v, input string tag);
        int   waitc = 0;
        int   cycles;
        logic done = 1'b0;
        logic walked = 1'b0;
        vec_t e;
        @(negedge clk);
        while (!RQST_READY && waitc < 10) begin
            @(negedge clk);
            waitc++;
        end
        chk({tag, " ready"}, 32'(RQST_READY), 32'd1);
        TRANS_RQST = 1'b1;
        VIRT_ADDR_LOOKUP = v.va;
        SPEC_TLB_RQST = v.spec;
        sb.push_back(v);
        @(negedge clk);
        TRANS_RQST = 1'b0;
        cycles = 1;
        while (!done && cycles < 40) begin
            WALK_DONE = 1'b0;
            FLUSH = 1'b0;
            if (WALK_RQST && !walked) begin
                walked = 1'b1;
                chk({tag, " walk_large"}, 32'(WALK_LARGE), 32'(v.wlarge));
                chk({tag, " walk_vpn"}, 32'(WALK_VPN), 32'(v.wvpn));
                WALK_DONE = 1'b1;
                WALK_FAULT = v.wfault;
                WALK_PPN = v.wppn;
                FLUSH = v.flush_in_walk;
            end
            if (DONE_TRANS) begin
                done = 1'b1;
                chk({tag, " sb_depth"}, 32'(sb.size()), 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk({tag, " tlb_hit"}, 32'(TLB_HIT), 32'(e.hit));
                    chk({tag, " spec_hit"}, 32'(SPEC_HIT), 32'(e.shit));
                    chk({tag, " fault"}, 32'(FAULT), 32'(e.fault));
                    chk({tag, " pa"}, 32'(PHY_ADDR_TRANS), 32'(e.pa));
                    if (!e.walk)
                        chk({tag, " hit_latency"}, 32'(cycles), 32'd2);
                end
            end
            @(negedge clk);
            cycles++;
        end
        WALK_DONE = 1'b0;
        FLUSH = 1'b0;
        chk({tag, " walked"}, 32'(walked), 32'(v.walk));
        chk({tag, " done_seen"}, 32'(done), 32'd1);
        chk({tag, " done_pulse"}, 32'(DONE_TRANS), 32'd0);
        chk({tag, " pa_hold"}, 32'(PHY_ADDR_TRANS), 32'(v.pa));
        sb.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       seen;
        logic [4:0] k;
        vec_t       v;
        rst = 1'b1; TRANS_RQST = 1'b0; SPEC_TLB_RQST = 1'b0; FLUSH = 1'b0;
        VIRT_ADDR_LOOKUP = '0; WALK_DONE = 1'b0; WALK_FAULT = 1'b0; WALK_PPN = '0;

        tbl[0] = mk(8'h2D, 0, 1, 0, 5'h05, 5'h11, 0, 0, 0, 0, 8'h8D);
        tbl[1] = mk(8'h2D, 0, 0, 0, 5'h00, 5'h00, 0, 1, 0, 0, 8'h8D);
        tbl[2] = mk(8'h47, 1, 1, 1, 5'h08, 5'h17, 0, 0, 0, 0, 8'hA7);
        tbl[3] = mk(8'h5A, 1, 0, 0, 5'h00, 5'h00, 0, 1, 1, 0, 8'hBA);
        tbl[4] = mk(8'h5A, 0, 1, 0, 5'h0B, 5'h03, 0, 0, 0, 0, 8'h1A);
        tbl[5] = mk(8'h5A, 1, 0, 0, 5'h00, 5'h00, 0, 1, 0, 0, 8'h1A);
        tbl[6] = mk(8'h2D, 1, 0, 0, 5'h00, 5'h00, 0, 1, 0, 0, 8'h8D);
        tbl[7] = mk(8'h90, 0, 1, 0, 5'h12, 5'h1F, 1, 0, 0, 1, 8'h00);
        tbl[8] = mk(8'h90, 0, 1, 0, 5'h12, 5'h1F, 0, 0, 0, 0, 8'hF8);
        tbl[9] = mk(8'h47, 0, 1, 0, 5'h08, 5'h02, 0, 0, 0, 0, 8'h17);

        @(negedge clk);
        @(negedge clk);
        chk("rst done", 32'(DONE_TRANS), 32'd0);
        chk("rst pa", 32'(PHY_ADDR_TRANS), 32'd0);
        chk("rst walk_rqst", 32'(WALK_RQST), 32'd0);
        chk("rst flags", 32'({TLB_HIT, SPEC_HIT, FAULT, WALK_LARGE}), 32'd0);
        chk("rst cnts", 32'(HIT_CNT | SPEC_HIT_CNT | MISS_CNT), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post-rst ready", 32'(RQST_READY), 32'd1);

        for (int i = 0; i < 10; i++)
            run(tbl[i], $sformatf("vec%0d", i));

        // FLUSH during a walk: result still delivered, then everything misses.
        v = mk(8'hC8, 0, 1, 0, 5'h19, 5'h04, 0, 0, 0, 0, 8'h20);
        v.flush_in_walk = 1'b1;
        run(v, "flushwalk");
        run(mk(8'h2D, 0, 1, 0, 5'h05, 5'h11, 0, 0, 0, 0, 8'h8D), "postflush 2D");
        run(mk(8'h5A, 1, 1, 1, 5'h0B, 5'h1C, 0, 0, 0, 0, 8'hFA), "postflush 5A");
        run(mk(8'hC8, 0, 1, 0, 5'h19, 5'h04, 0, 0, 0, 0, 8'h20), "postflush C8");

        // FLUSH in IDLE with a simultaneous request: request dropped.
        @(negedge clk);
        FLUSH = 1'b1; TRANS_RQST = 1'b1; VIRT_ADDR_LOOKUP = 8'h2D; SPEC_TLB_RQST = 1'b0;
        #1;
        chk("idleflush ready", 32'(RQST_READY), 32'd0);
        @(negedge clk);
        FLUSH = 1'b0; TRANS_RQST = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (DONE_TRANS || WALK_RQST) seen = 1'b1;
            @(negedge clk);
        end
        chk("idleflush ignored", 32'(seen), 32'd0);
        run(mk(8'h2D, 0, 1, 0, 5'h05, 5'h11, 0, 0, 0, 0, 8'h8D), "idleflush 2D");

        // Round-robin replacement once all 8 entries are valid.
        reset_dut();
        for (int i = 0; i < 10; i++) begin
            k = 5'(i);
            run(mk({k, 3'b010}, 0, 1, 0, k, 5'(k + 5'd2), 0, 0, 0, 0, {5'(k + 5'd2), 3'b010}),
                $sformatf("fill%0d", i));
        end
        run(mk({5'd2, 3'b010}, 0, 0, 0, 5'd0, 5'd0, 0, 1, 0, 0, {5'd4, 3'b010}), "rr keep2");
        run(mk({5'd8, 3'b010}, 0, 0, 0, 5'd0, 5'd0, 0, 1, 0, 0, {5'd10, 3'b010}), "rr keep8");
        run(mk({5'd9, 3'b010}, 0, 0, 0, 5'd0, 5'd0, 0, 1, 0, 0, {5'd11, 3'b010}), "rr keep9");
        run(mk({5'd0, 3'b010}, 0, 1, 0, 5'd0, 5'd7, 0, 0, 0, 0, {5'd7, 3'b010}), "rr evict0");
        run(mk({5'd1, 3'b010}, 0, 1, 0, 5'd1, 5'd6, 0, 0, 0, 0, {5'd6, 3'b010}), "rr evict1");

        // rst while the walk is outstanding.
        @(negedge clk);
        TRANS_RQST = 1'b1; VIRT_ADDR_LOOKUP = 8'hE0; SPEC_TLB_RQST = 1'b0;
        @(negedge clk);
        TRANS_RQST = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (WALK_RQST) seen = 1'b1;
            else @(negedge clk);
        end
        chk("rstwalk walk_rqst", 32'(seen), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstwalk rqst_low", 32'(WALK_RQST), 32'd0);
        WALK_DONE = 1'b1; WALK_FAULT = 1'b0; WALK_PPN = 5'h0F;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (DONE_TRANS) seen = 1'b1;
            @(negedge clk);
            WALK_DONE = 1'b0;
        end
        chk("rstwalk no_done", 32'(seen), 32'd0);
        chk("rstwalk ready", 32'(RQST_READY), 32'd1);
        run(mk(8'h2D, 0, 1, 0, 5'h05, 5'h11, 0, 0, 0, 0, 8'h8D), "rstwalk 2D");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
